// File: rtl/reorder_buffer_pkg.sv
// -----------------------------------------------------------------------------
// reorder_buffer_pkg
//   Shared constants and helpers for the reorder buffer slice.
//   - DATA_W     : width of result values carried on the CDB and committed
//   - REG_W      : architectural register index width
//   - ROB_W_DEF  : default ROB id width
//   - ROB_N_DEF  : default entry count (ids 1..ROB_N, id 0 means "none")
//   - rob_next_id: pointer advance that wraps from ROB_N back to 1, never 0
// Optional feature macro used by this slice: ROB_QUERY_FORWARD_EN
// -----------------------------------------------------------------------------
package reorder_buffer_pkg;

  localparam int DATA_W    = 32;
  localparam int REG_W     = 5;
  localparam int ROB_W_DEF = 4;
  localparam int ROB_N_DEF = 15;

  // Id 0 is reserved, so the ring runs 1..n and skips 0 on wrap.
  function automatic int unsigned rob_next_id(input int unsigned p, input int unsigned n);
    return (p == n) ? 32'd1 : p + 32'd1;
  endfunction

endpackage

// File: rtl/reorder_buffer_query_port.sv
// -----------------------------------------------------------------------------
// rob_query_port
//   Combinational operand-readiness lookup for one decoder source operand.
//   Ports:
//     query_id        in  ROB_W        producer id being asked about
//     busy/ready      in  ROB_N+1      per-entry state (index 0 unused)
//     value           in  ROB_N+1 x 32 per-entry stored result
//     cdb_alu_*       in               ALU broadcast this cycle
//     cdb_mem_*       in               MEM broadcast this cycle
//     query_ready     out 1            operand value is available
//     query_value     out 32           operand value (0 when not available)
//   With ROB_QUERY_FORWARD_EN defined, a live CDB broadcast for the queried
//   id is forwarded directly (MEM wins over ALU); otherwise only stored state
//   is visible.
// -----------------------------------------------------------------------------
module rob_query_port
  import reorder_buffer_pkg::*;
#(
  parameter int ROB_W = ROB_W_DEF,
  parameter int ROB_N = ROB_N_DEF
) (
  input  logic [ROB_W-1:0]              query_id,
  input  logic [ROB_N:0]                busy,
  input  logic [ROB_N:0]                ready,
  input  logic [ROB_N:0][DATA_W-1:0]    value,
  input  logic [ROB_W-1:0]              cdb_alu_rob_id,
  input  logic [DATA_W-1:0]             cdb_alu_value,
  input  logic [ROB_W-1:0]              cdb_mem_rob_id,
  input  logic [DATA_W-1:0]             cdb_mem_value,
  output logic                          query_ready,
  output logic [DATA_W-1:0]             query_value
);

  // Slot 0 never holds an instruction; id 0 answers "ready, zero" below.
  logic unused_slot0;
  assign unused_slot0 = ^{busy[0], ready[0], value[0]};

`ifndef ROB_QUERY_FORWARD_EN
  logic unused_cdb;
  assign unused_cdb = ^{cdb_alu_rob_id, cdb_alu_value, cdb_mem_rob_id, cdb_mem_value};
`endif

  always_comb begin
    // Id 0 and non-busy entries read as ready with value 0.
    query_ready = 1'b1;
    query_value = '0;
    for (int i = 1; i <= ROB_N; i++) begin
      if (query_id == ROB_W'(i) && busy[i]) begin
        query_ready = ready[i];
        query_value = ready[i] ? value[i] : '0;
      end
    end
`ifdef ROB_QUERY_FORWARD_EN
    // Bridges the cycle between a broadcast and its capture into the entry.
    if (query_id != '0) begin
      if (cdb_mem_rob_id == query_id) begin
        query_ready = 1'b1;
        query_value = cdb_mem_value;
      end else if (cdb_alu_rob_id == query_id) begin
        query_ready = 1'b1;
        query_value = cdb_alu_value;
      end
    end
`endif
  end

endmodule

// File: rtl/reorder_buffer.sv
// -----------------------------------------------------------------------------
// reorder_buffer
//   In-order reorder buffer at the consumer end of the CDB.
//   Ports:
//     clk_in, rst_in (async, active-low), flush_input (sync clear)
//     alloc_valid/alloc_dest_reg  in   decoder allocation request
//     alloc_rob_id                out  id the next allocation receives (tail)
//     has_no_vacancy/has_one_vacancy out  count == ROB_N / ROB_N-1
//     cdb_alu_*/cdb_mem_*         in   result broadcasts (id 0 = idle)
//     query_j_*/query_k_*              operand readiness lookups
//     commit_rob_id/reg/value     out  registered retirement (id 0 = none)
//   Optional feature macro: ROB_QUERY_FORWARD_EN (CDB-to-query forwarding,
//   implemented in rob_query_port).
// -----------------------------------------------------------------------------
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int ROB_W = ROB_W_DEF,
  parameter int ROB_N = ROB_N_DEF
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 flush_input,
  input  logic                 alloc_valid,
  input  logic [REG_W-1:0]     alloc_dest_reg,
  output logic [ROB_W-1:0]     alloc_rob_id,
  output logic                 has_no_vacancy,
  output logic                 has_one_vacancy,
  input  logic [ROB_W-1:0]     cdb_alu_rob_id,
  input  logic [DATA_W-1:0]    cdb_alu_value,
  input  logic [ROB_W-1:0]     cdb_mem_rob_id,
  input  logic [DATA_W-1:0]    cdb_mem_value,
  input  logic [ROB_W-1:0]     query_j_rob_id,
  output logic                 query_j_ready,
  output logic [DATA_W-1:0]    query_j_value,
  input  logic [ROB_W-1:0]     query_k_rob_id,
  output logic                 query_k_ready,
  output logic [DATA_W-1:0]    query_k_value,
  output logic [ROB_W-1:0]     commit_rob_id,
  output logic [REG_W-1:0]     commit_reg,
  output logic [DATA_W-1:0]    commit_value
);

  localparam int CNT_W = $clog2(ROB_N + 1);

  // Control state (reset)
  logic [ROB_N:0]             busy_q, busy_d;
  logic [ROB_N:0]             ready_q, ready_d;
  logic [ROB_W-1:0]           head_q, head_d;
  logic [ROB_W-1:0]           tail_q, tail_d;
  logic [CNT_W-1:0]           count_q, count_d;
  logic [ROB_W-1:0]           commit_id_q, commit_id_d;
  logic [REG_W-1:0]           commit_reg_q, commit_reg_d;
  logic [DATA_W-1:0]          commit_value_q, commit_value_d;

  // Entry payload (no reset; only meaningful while busy)
  logic [ROB_N:0][REG_W-1:0]  dest_q, dest_d;
  logic [ROB_N:0][DATA_W-1:0] value_q, value_d;

  logic alloc_fire;
  logic commit_fire;

  function automatic logic [ROB_W-1:0] next_id(input logic [ROB_W-1:0] p);
    return ROB_W'(rob_next_id(32'(p), 32'(ROB_N)));
  endfunction

  assign alloc_fire  = alloc_valid && (count_q < CNT_W'(ROB_N));
  assign commit_fire = busy_q[head_q] && ready_q[head_q];

  always_comb begin
    busy_d         = busy_q;
    ready_d        = ready_q;
    dest_d         = dest_q;
    value_d        = value_q;
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    commit_id_d    = '0;
    commit_reg_d   = commit_reg_q;
    commit_value_d = commit_value_q;

    if (flush_input) begin
      busy_d         = '0;
      ready_d        = '0;
      head_d         = ROB_W'(1);
      tail_d         = ROB_W'(1);
      count_d        = '0;
      commit_reg_d   = '0;
      commit_value_d = '0;
    end else begin
      // CDB capture; MEM is applied last so it wins a same-id collision.
      for (int i = 1; i <= ROB_N; i++) begin
        if (busy_q[i]) begin
          if (cdb_alu_rob_id == ROB_W'(i)) begin
            ready_d[i] = 1'b1;
            value_d[i] = cdb_alu_value;
          end
          if (cdb_mem_rob_id == ROB_W'(i)) begin
            ready_d[i] = 1'b1;
            value_d[i] = cdb_mem_value;
          end
        end
      end

      // Retire from cycle-start state so a capture never commits same cycle.
      if (commit_fire) begin
        commit_id_d     = head_q;
        commit_reg_d    = dest_q[head_q];
        commit_value_d  = value_q[head_q];
        busy_d[head_q]  = 1'b0;
        ready_d[head_q] = 1'b0;
        head_d          = next_id(head_q);
      end

      // Tail slot is free whenever count < ROB_N, so no capture can hit it.
      if (alloc_fire) begin
        busy_d[tail_q]  = 1'b1;
        ready_d[tail_q] = 1'b0;
        dest_d[tail_q]  = alloc_dest_reg;
        tail_d          = next_id(tail_q);
      end

      count_d = count_q + CNT_W'(alloc_fire) - CNT_W'(commit_fire);
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy_q         <= '0;
      ready_q        <= '0;
      head_q         <= ROB_W'(1);
      tail_q         <= ROB_W'(1);
      count_q        <= '0;
      commit_id_q    <= '0;
      commit_reg_q   <= '0;
      commit_value_q <= '0;
    end else begin
      busy_q         <= busy_d;
      ready_q        <= ready_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      commit_id_q    <= commit_id_d;
      commit_reg_q   <= commit_reg_d;
      commit_value_q <= commit_value_d;
    end
  end

  always_ff @(posedge clk_in) begin
    dest_q  <= dest_d;
    value_q <= value_d;
  end

  assign alloc_rob_id    = tail_q;
  assign has_no_vacancy  = (count_q == CNT_W'(ROB_N));
  assign has_one_vacancy = (count_q == CNT_W'(ROB_N - 1));
  assign commit_rob_id   = commit_id_q;
  assign commit_reg      = commit_reg_q;
  assign commit_value    = commit_value_q;

  rob_query_port #(.ROB_W(ROB_W), .ROB_N(ROB_N)) u_query_j (
    .query_id       (query_j_rob_id),
    .busy           (busy_q),
    .ready          (ready_q),
    .value          (value_q),
    .cdb_alu_rob_id (cdb_alu_rob_id),
    .cdb_alu_value  (cdb_alu_value),
    .cdb_mem_rob_id (cdb_mem_rob_id),
    .cdb_mem_value  (cdb_mem_value),
    .query_ready    (query_j_ready),
    .query_value    (query_j_value)
  );

  rob_query_port #(.ROB_W(ROB_W), .ROB_N(ROB_N)) u_query_k (
    .query_id       (query_k_rob_id),
    .busy           (busy_q),
    .ready          (ready_q),
    .value          (value_q),
    .cdb_alu_rob_id (cdb_alu_rob_id),
    .cdb_alu_value  (cdb_alu_value),
    .cdb_mem_rob_id (cdb_mem_rob_id),
    .cdb_mem_value  (cdb_mem_value),
    .query_ready    (query_k_ready),
    .query_value    (query_k_value)
  );

endmodule
